// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
// Issues sequential PCs to imem, queues returned words, handles redirects.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   imem_req_valid/ready, addr    request channel (addr = fetch PC)
//   imem_rsp_valid, rsp_data      in-order responses, one per accepted request
//   redirect_valid, redirect_pc   taken branch/jump, flushes the stage
//   out_valid/ready, instr, pc    {instr, pc} handshake to the decoder
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [AW-1:0] ptr_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    logic        run_q;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] rsp_pc_q, rsp_pc_d;
    cnt_t        count_q, count_d;
    cnt_t        outst_q, outst_d;
    cnt_t        discard_q, discard_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    ptr_t        wr_ptr_q, wr_ptr_d;
    logic [31:0] instr_q [DEPTH];
    logic [31:0] pc_q    [DEPTH];

    logic        req_fire;
    logic        rsp_ok;
    logic        rsp_drop;
    logic        push;
    logic        pop;
    cnt_t        outst_rsp;
    logic [CW:0] credit_used;
    logic [31:0] target_pc;
    logic        unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign target_pc = {redirect_pc[31:2], 2'b00};

    // Queued words plus words still in flight must fit in the FIFO,
    // so a response can always be pushed without checking for full.
    assign credit_used    = {1'b0, count_q} + {1'b0, outst_q};
    assign imem_req_valid = run_q && !redirect_valid
                          && (credit_used < {1'b0, DEPTH_C});
    assign imem_addr      = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error: ignored.
    assign rsp_ok   = imem_rsp_valid && (outst_q != '0);
    assign rsp_drop = rsp_ok && (discard_q != '0);
    assign push     = rsp_ok && !rsp_drop && !redirect_valid;

    assign out_valid = (count_q != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign out_instr = instr_q[rd_ptr_q];
    assign out_pc    = pc_q[rd_ptr_q];

    assign outst_rsp = outst_q - cnt_t'(rsp_ok);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        outst_d    = outst_rsp + cnt_t'(req_fire);
        discard_d  = discard_q - cnt_t'(rsp_drop);
        count_d    = count_q + cnt_t'(push) - cnt_t'(pop);
        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (push) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
        if (redirect_valid) begin
            fetch_pc_d = target_pc;
            rsp_pc_d   = target_pc;
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            wr_ptr_d   = wr_ptr_q;
            // outstanding counts every word in flight, including ones
            // already marked for discard, so after a redirect all of
            // them are stale: discard becomes the whole in-flight count.
            discard_d  = outst_rsp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            run_q      <= 1'b1;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= RESET_PC;
            end
        end else if (push) begin
            instr_q[wr_ptr_q] <= imem_rsp_data;
            pc_q[wr_ptr_q]    <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a variable-latency
// in-order memory model and an output monitor.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lat      = 1;

    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    logic [31:0] acc       [$];
    logic [31:0] got_pc    [$];
    logic [31:0] got_ins   [$];

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (2)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {~a[15:0], a[15:0] ^ 16'h5A5A};
    endfunction

    // Memory model and monitor: inputs change only at posedge+1, so
    // values seen at the negedge are what the next posedge samples.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_addr.delete();
            pend_due.delete();
            acc.delete();
            got_pc.delete();
            got_ins.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end else begin
            if (pend_addr.size() > 0 && cyc >= pend_due[0]) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memf(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
            if (imem_req_valid && imem_req_ready) begin
                pend_addr.push_back(imem_addr);
                pend_due.push_back(cyc + lat);
                acc.push_back(imem_addr);
            end
            if (out_valid && out_ready) begin
                got_pc.push_back(out_pc);
                got_ins.push_back(out_instr);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy, input logic ordy, input int l);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = rdy;
        out_ready      = ordy;
        lat            = l;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_seq(input string tag, input int n, input logic [31:0] base);
        chk({tag, "_n"}, 32'(got_pc.size() >= n), 32'd1);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_pc"}, got_pc[i], base + 32'(4 * i));
            chk({tag, "_ins"}, got_ins[i], memf(base + 32'(4 * i)));
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset values and zero-wait streaming
        do_reset(1'b1, 1'b1, 1);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        tick();
        chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_addr0", imem_addr, 32'h0);
        chk("t1_ov_c1", 32'(out_valid), 32'd0);
        tick();
        chk("t1_ov_c2", 32'(out_valid), 32'd0);
        tick();
        chk("t1_ov_c3", 32'(out_valid), 32'd1);
        chk("t1_pc_c3", out_pc, 32'h0);
        chk("t1_ins_c3", out_instr, memf(32'h0));
        repeat (12) tick();
        chk_seq("t1", 5, 32'h0);
        for (int i = 0; i < 5; i++) chk("t1_acc", acc[i], 32'(4 * i));

        // Decoder backpressure
        do_reset(1'b1, 1'b0, 1);
        repeat (10) tick();
        chk("t2_acc_n", 32'(acc.size()), 32'd2);
        chk("t2_req_valid", 32'(imem_req_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("t2_ov", 32'(out_valid), 32'd1);
            chk("t2_pc", out_pc, 32'h0);
            chk("t2_ins", out_instr, memf(32'h0));
            tick();
        end
        out_ready = 1'b1;
        repeat (12) tick();
        chk_seq("t2", 3, 32'h0);
        chk("t2_acc2", acc[2], 32'h8);

        // Memory stall, then 3-cycle latency
        do_reset(1'b0, 1'b1, 3);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t3_req_valid", 32'(imem_req_valid), 32'd1);
            chk("t3_addr_hold", imem_addr, 32'h0);
            tick();
        end
        imem_req_ready = 1'b1;
        repeat (30) tick();
        chk_seq("t3", 5, 32'h0);
        for (int i = 0; i < 5; i++) chk("t3_acc", acc[i], 32'(4 * i));

        // Redirect with one queued entry and one in flight
        do_reset(1'b1, 1'b0, 1);
        repeat (2) tick();
        lat = 4;
        tick();
        chk("t4_ov_pre", 32'(out_valid), 32'd1);
        chk("t4_pc_pre", out_pc, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        out_ready      = 1'b1;
        lat            = 1;
        #1;
        chk("t4_ov_redir", 32'(out_valid), 32'd0);
        chk("t4_rv_redir", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t4_rv_next", 32'(imem_req_valid), 32'd1);
        chk("t4_addr_next", imem_addr, 32'h100);
        repeat (15) tick();
        chk_seq("t4", 2, 32'h100);

        // Redirect on a response cycle, then a second redirect
        do_reset(1'b1, 1'b0, 1);
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0150;
        tick();
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        repeat (12) tick();
        chk_seq("t5", 3, 32'h200);
        chk("t5_discard", 32'(u_dut.discard_q), 32'd0);

        // Reset asserted mid-stream
        do_reset(1'b1, 1'b0, 1);
        repeat (3) tick();
        chk("t6_ov_pre", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_out_instr", out_instr, 32'd0);
        chk("t6_out_pc", out_pc, 32'd0);
        repeat (2) tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (12) tick();
        chk("t6_acc0", acc[0], 32'h0);
        chk_seq("t6", 2, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
